// File: rtl/exmem_memwb_regs_if.sv
// Data-memory request/response bus between the EX/MEM stage and the data memory.
interface exmem_memwb_regs_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/exmem_memwb_regs.sv
// EX/MEM and MEM/WB pipeline registers with data-memory request formatting,
// load extraction, stall/flush handling and a saturating stall counter.
module exmem_memwb_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        flush_ex,
  exmem_memwb_regs_if.master mem,
  output logic        ex_stall,
  output logic        exmem_regwrite,
  output logic [4:0]  exmem_rd,
  output logic [31:0] exmem_alu_result,
  output logic        memwb_regwrite,
  output logic [4:0]  memwb_rd,
  output logic [31:0] memwb_wb_data,
  output logic [15:0] mem_stall_count
);

  logic        exmem_valid;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic        exmem_memtoreg;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_store_data;
  logic        pending_flush;

  logic        req;
  logic        mem_stall;
  logic [1:0]  byte_sel;
  logic [31:0] store_word;
  logic [3:0]  store_strb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign req           = exmem_valid & (exmem_memread | exmem_memwrite);
  assign mem_stall     = req & ~mem.mem_ready;
  assign ex_stall      = mem_stall;
  assign byte_sel      = exmem_alu_result[1:0];
  assign mem.mem_req   = req;
  assign mem.mem_we    = exmem_memwrite & req;
  assign mem.mem_addr  = exmem_alu_result;
  assign mem.mem_wdata = store_word;
  assign mem.mem_wstrb = mem.mem_we ? store_strb : '0;

  always_comb begin
    store_word = exmem_store_data;
    store_strb = '1;
    case (exmem_funct3)
      3'b000: begin
        store_word = {4{exmem_store_data[7:0]}};
        store_strb = 4'b0001 << byte_sel;
      end
      3'b001: begin
        store_word = {2{exmem_store_data[15:0]}};
        store_strb = byte_sel[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (byte_sel)
      2'd0:    load_byte = mem.mem_rdata[7:0];
      2'd1:    load_byte = mem.mem_rdata[15:8];
      2'd2:    load_byte = mem.mem_rdata[23:16];
      default: load_byte = mem.mem_rdata[31:24];
    endcase
    load_half = byte_sel[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (exmem_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_valid      <= 1'b0;
      exmem_regwrite   <= 1'b0;
      exmem_memread    <= 1'b0;
      exmem_memwrite   <= 1'b0;
      exmem_memtoreg   <= 1'b0;
      exmem_rd         <= '0;
      exmem_funct3     <= '0;
      exmem_alu_result <= '0;
      exmem_store_data <= '0;
      memwb_regwrite   <= 1'b0;
      memwb_rd         <= '0;
      memwb_wb_data    <= '0;
      pending_flush    <= 1'b0;
      mem_stall_count  <= '0;
    end else if (mem_stall) begin
      // EX/MEM holds; a flush arriving now is remembered until the op completes
      memwb_regwrite <= 1'b0;
      memwb_rd       <= '0;
      memwb_wb_data  <= '0;
      if (flush_ex)
        pending_flush <= 1'b1;
      if (mem_stall_count != '1)
        mem_stall_count <= mem_stall_count + 16'd1;
    end else begin
      memwb_regwrite <= exmem_regwrite;
      memwb_rd       <= exmem_rd;
      memwb_wb_data  <= exmem_memtoreg ? load_data : exmem_alu_result;
      pending_flush  <= 1'b0;
      if (flush_ex | pending_flush) begin
        exmem_valid      <= 1'b0;
        exmem_regwrite   <= 1'b0;
        exmem_memread    <= 1'b0;
        exmem_memwrite   <= 1'b0;
        exmem_memtoreg   <= 1'b0;
        exmem_rd         <= '0;
        exmem_funct3     <= '0;
        exmem_alu_result <= '0;
        exmem_store_data <= '0;
      end else begin
        exmem_valid      <= ex_valid;
        exmem_regwrite   <= ex_valid & ex_regwrite;
        exmem_memread    <= ex_memread;
        exmem_memwrite   <= ex_memwrite;
        exmem_memtoreg   <= ex_memtoreg;
        exmem_rd         <= ex_rd;
        exmem_funct3     <= ex_funct3;
        exmem_alu_result <= ex_alu_result;
        exmem_store_data <= ex_store_data;
      end
    end
  end

endmodule

// File: tb/tb_exmem_memwb_regs.sv
// Randomized and directed checks of the EX/MEM and MEM/WB registers against a
// transaction-level reference model.
module tb_exmem_memwb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        flush_ex;
  logic        ex_stall;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wb_data;
  logic [15:0] mem_stall_count;

  int checks = 0;
  int errors = 0;

  exmem_memwb_regs_if bus ();

  exmem_memwb_regs dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_regwrite      (ex_regwrite),
    .ex_memread       (ex_memread),
    .ex_memwrite      (ex_memwrite),
    .ex_memtoreg      (ex_memtoreg),
    .ex_rd            (ex_rd),
    .ex_funct3        (ex_funct3),
    .ex_alu_result    (ex_alu_result),
    .ex_store_data    (ex_store_data),
    .flush_ex         (flush_ex),
    .mem              (bus),
    .ex_stall         (ex_stall),
    .exmem_regwrite   (exmem_regwrite),
    .exmem_rd         (exmem_rd),
    .exmem_alu_result (exmem_alu_result),
    .memwb_regwrite   (memwb_regwrite),
    .memwb_rd         (memwb_rd),
    .memwb_wb_data    (memwb_wb_data),
    .mem_stall_count  (mem_stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: one instruction slot in MEM, one result slot in WB
  typedef struct packed {
    logic        valid, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu, sdata;
  } slot_t;

  slot_t       m_ex;
  logic        m_wb_rw;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  bit          m_pend;
  int unsigned m_cnt;

  function automatic logic [31:0] load_value(logic [2:0] f3, logic [31:0] addr, logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (32'(addr[1:0]) * 8)) & 32'hFF;
    h = (word >> (32'(addr[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Returns {strobe, write data}
  function automatic logic [35:0] store_fmt(logic [2:0] f3, logic [31:0] addr, logic [31:0] data);
    case (f3)
      3'd0:    return {4'(32'd1 << addr[1:0]), 32'(data[7:0]) * 32'h01010101};
      3'd1:    return {(addr[1] ? 4'd12 : 4'd3), 32'(data[15:0]) * 32'h00010001};
      default: return {4'hF, data};
    endcase
  endfunction

  function automatic bit model_req();
    return m_ex.valid && (m_ex.memread || m_ex.memwrite);
  endfunction

  task automatic model_step();
    bit stall;
    if (rst) begin
      m_ex = '0; m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0; m_pend = 0; m_cnt = 0;
    end else begin
      stall = model_req() && !bus.mem_ready;
      if (stall) begin
        m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0;
        if (flush_ex) m_pend = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_wb_rw   = m_ex.valid && m_ex.regwrite;
        m_wb_rd   = m_ex.rd;
        m_wb_data = m_ex.memtoreg ? load_value(m_ex.funct3, m_ex.alu, bus.mem_rdata) : m_ex.alu;
        if (flush_ex || m_pend)
          m_ex = '0;
        else
          m_ex = '{ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                   ex_rd, ex_funct3, ex_alu_result, ex_store_data};
        m_pend = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 0; flush_ex = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0;
    ex_rd = 0; ex_funct3 = 0; ex_alu_result = 0; ex_store_data = 0;
    bus.mem_ready = 1; bus.mem_rdata = 0;
  endtask

  task automatic set_instr(logic rw, logic rd_mem, logic wr_mem, logic [4:0] rd,
                           logic [2:0] f3, logic [31:0] alu, logic [31:0] sdata);
    ex_valid = 1; ex_regwrite = rw; ex_memread = rd_mem; ex_memwrite = wr_mem;
    ex_memtoreg = rd_mem; ex_rd = rd; ex_funct3 = f3; ex_alu_result = alu; ex_store_data = sdata;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; set_instr(1, 1, 0, 5'd3, 3'd2, 32'h10, 0); tick();
    set_idle();
    checks++;
    if ({exmem_regwrite, exmem_rd, exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data,
         mem_stall_count} !== '0) begin
      errors++; $display("FAIL reset_regs: got %h required 0", {exmem_regwrite, exmem_rd,
        exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data, mem_stall_count});
    end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, ex_stall} !== 7'd0) begin
      errors++; $display("FAIL reset_bus: req=%b we=%b strb=%b stall=%b required all 0",
        bus.mem_req, bus.mem_we, bus.mem_wstrb, ex_stall);
    end
  endtask

  task automatic test_alu();
    do_reset();
    set_instr(1, 0, 0, 5'd5, 3'd0, 32'h1234, 32'h0);
    tick(); set_idle();
    checks++;
    if ({exmem_regwrite, exmem_rd, exmem_alu_result} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL alu_exmem: got rw=%b rd=%0d alu=%h required 1/5/1234",
        exmem_regwrite, exmem_rd, exmem_alu_result);
    end
    tick();
    checks++;
    if ({memwb_regwrite, memwb_rd, memwb_wb_data} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL alu_memwb: got rw=%b rd=%0d data=%h required 1/5/1234",
        memwb_regwrite, memwb_rd, memwb_wb_data);
    end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s [2] = '{3'd0, 3'd4};
    logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      set_instr(1, 1, 0, 5'd7, f3s[i], 32'h103, 0);
      tick(); set_idle();
      bus.mem_ready = 1; bus.mem_rdata = 32'h80FF0000;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, ex_stall} !== {1'b1, 1'b0, 32'h103, 1'b0}) begin
        errors++; $display("FAIL load_req: req=%b we=%b addr=%h stall=%b required 1/0/103/0",
          bus.mem_req, bus.mem_we, bus.mem_addr, ex_stall);
      end
      tick();
      checks++;
      if ({memwb_regwrite, memwb_rd, memwb_wb_data} !== {1'b1, 5'd7, exp[i]}) begin
        errors++; $display("FAIL load_fmt f3=%0d: got rw=%b rd=%0d data=%h required 1/7/%h",
          f3s[i], memwb_regwrite, memwb_rd, memwb_wb_data, exp[i]);
      end
    end
  endtask

  task automatic test_store_format();
    do_reset();
    set_instr(0, 0, 1, 5'd0, 3'd1, 32'h102, 32'h0000ABCD);
    tick(); set_idle();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !== {1'b1, 1'b1, 32'hABCDABCD, 4'b1100}) begin
      errors++; $display("FAIL store_sh: req=%b we=%b wdata=%h strb=%b required 1/1/abcdabcd/1100",
        bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_wstrb);
    end
    tick();
    checks++;
    if (memwb_regwrite !== 1'b0) begin
      errors++; $display("FAIL store_no_wb: memwb_regwrite=%b required 0", memwb_regwrite);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_instr(1, 1, 0, 5'd9, 3'd2, 32'h200, 0);
    tick();
    set_instr(1, 0, 0, 5'd10, 3'd0, 32'h55, 0);
    bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ex_stall !== 1'b1) begin
        errors++; $display("FAIL stall_flag c%0d: ex_stall=%b required 1", i, ex_stall);
      end
      tick();
      checks++;
      if ({exmem_rd, exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data} !==
          {5'd9, 32'h200, 1'b0, 5'd0, 32'd0}) begin
        errors++; $display("FAIL stall_hold c%0d: exmem rd=%0d alu=%h memwb rw=%b rd=%0d data=%h required 9/200/0/0/0",
          i, exmem_rd, exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data);
      end
    end
    checks++;
    if (mem_stall_count !== 16'd3) begin
      errors++; $display("FAIL stall_count: got %0d required 3", mem_stall_count);
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick(); set_idle();
    checks++;
    if ({memwb_rd, memwb_wb_data, exmem_rd, exmem_regwrite} !== {5'd9, 32'hDEADBEEF, 5'd10, 1'b1}) begin
      errors++; $display("FAIL stall_release: memwb rd=%0d data=%h exmem rd=%0d rw=%b required 9/deadbeef/10/1",
        memwb_rd, memwb_wb_data, exmem_rd, exmem_regwrite);
    end
  endtask

  task automatic test_flush_during_stall();
    do_reset();
    set_instr(1, 1, 0, 5'd11, 3'd2, 32'h40, 0);
    tick();
    set_instr(1, 0, 0, 5'd12, 3'd0, 32'h77, 0);
    bus.mem_ready = 0; flush_ex = 1;
    tick();
    flush_ex = 0;
    tick();
    bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
    tick();
    checks++;
    if ({exmem_regwrite, exmem_rd, exmem_alu_result, memwb_rd, memwb_wb_data} !==
        {1'b0, 5'd0, 32'd0, 5'd11, 32'h11112222}) begin
      errors++; $display("FAIL flush_bubble: exmem rw=%b rd=%0d alu=%h memwb rd=%0d data=%h required 0/0/0/11/11112222",
        exmem_regwrite, exmem_rd, exmem_alu_result, memwb_rd, memwb_wb_data);
    end
    set_instr(1, 0, 0, 5'd13, 3'd0, 32'h99, 0);
    tick(); set_idle();
    checks++;
    if ({exmem_regwrite, exmem_rd, exmem_alu_result, mem_stall_count} !== {1'b1, 5'd13, 32'h99, 16'd2}) begin
      errors++; $display("FAIL flush_cleared: exmem rw=%b rd=%0d alu=%h count=%0d required 1/13/99/2",
        exmem_regwrite, exmem_rd, exmem_alu_result, mem_stall_count);
    end
  endtask

  task automatic test_random();
    logic [35:0] sf;
    logic        exp_req, exp_we;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      flush_ex = ($urandom_range(0, 99) < 10);
      ex_valid = ($urandom_range(0, 99) < 80);
      ex_regwrite = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: begin ex_memread = 0; ex_memwrite = 0; end
        1: begin ex_memread = 1; ex_memwrite = 0; end
        default: begin ex_memread = 0; ex_memwrite = 1; end
      endcase
      ex_memtoreg = ex_memread;
      ex_rd = 5'($urandom);
      ex_funct3 = 3'($urandom);
      ex_alu_result = $urandom;
      ex_store_data = $urandom;
      bus.mem_ready = ($urandom_range(0, 99) < 65);
      bus.mem_rdata = $urandom;
      #1;
      exp_req = model_req();
      exp_we  = exp_req && m_ex.memwrite;
      sf = store_fmt(m_ex.funct3, m_ex.alu, m_ex.sdata);
      checks++;
      if ({bus.mem_req, bus.mem_we, ex_stall, bus.mem_wstrb} !==
          {exp_req, exp_we, exp_req && !bus.mem_ready, exp_we ? sf[35:32] : 4'd0}) begin
        errors++; $display("FAIL rand_bus n=%0d: req=%b we=%b stall=%b strb=%b required %b/%b/%b/%b",
          n, bus.mem_req, bus.mem_we, ex_stall, bus.mem_wstrb,
          exp_req, exp_we, exp_req && !bus.mem_ready, exp_we ? sf[35:32] : 4'd0);
      end
      if (exp_req) begin
        checks++;
        if (bus.mem_addr !== m_ex.alu) begin
          errors++; $display("FAIL rand_addr n=%0d: got %h required %h", n, bus.mem_addr, m_ex.alu);
        end
      end
      if (exp_we) begin
        checks++;
        if (bus.mem_wdata !== sf[31:0]) begin
          errors++; $display("FAIL rand_wdata n=%0d: got %h required %h", n, bus.mem_wdata, sf[31:0]);
        end
      end
      tick();
      checks++;
      if ({exmem_regwrite, exmem_rd, exmem_alu_result} !== {m_ex.valid && m_ex.regwrite, m_ex.rd, m_ex.alu}) begin
        errors++; $display("FAIL rand_exmem n=%0d: got %b/%0d/%h required %b/%0d/%h", n,
          exmem_regwrite, exmem_rd, exmem_alu_result, m_ex.valid && m_ex.regwrite, m_ex.rd, m_ex.alu);
      end
      checks++;
      if ({memwb_regwrite, memwb_rd, memwb_wb_data, mem_stall_count} !== {m_wb_rw, m_wb_rd, m_wb_data, 16'(m_cnt)}) begin
        errors++; $display("FAIL rand_memwb n=%0d: got %b/%0d/%h cnt=%0d required %b/%0d/%h cnt=%0d", n,
          memwb_regwrite, memwb_rd, memwb_wb_data, mem_stall_count, m_wb_rw, m_wb_rd, m_wb_data, m_cnt);
      end
    end
    set_idle();
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    set_instr(1, 1, 0, 5'd3, 3'd2, 32'h80, 0);
    tick(); set_idle();
    bus.mem_ready = 0;
    repeat (65534) tick();
    checks++;
    if (mem_stall_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_preload: got %h required fffe", mem_stall_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_stall_count !== 16'hFFFF) begin
        errors++; $display("FAIL sat_hold c%0d: got %h required ffff", i, mem_stall_count);
      end
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if ({exmem_regwrite, exmem_rd, exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data,
         mem_stall_count} !== '0) begin
      errors++; $display("FAIL sat_reset_regs: got %h required 0", {exmem_regwrite, exmem_rd,
        exmem_alu_result, memwb_regwrite, memwb_rd, memwb_wb_data, mem_stall_count});
    end
    checks++;
    if ({bus.mem_req, ex_stall} !== 2'b00) begin
      errors++; $display("FAIL sat_reset_req: req=%b stall=%b required 0/0", bus.mem_req, ex_stall);
    end
  endtask

  initial begin
    set_idle();
    m_ex = '0; m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0; m_pend = 0; m_cnt = 0;
    test_reset();
    test_alu();
    test_load_format();
    test_store_format();
    test_stall();
    test_flush_during_stall();
    test_random();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
